// File: rtl/axi_dma_rd_arbiter.sv
// rtl/axi_dma_rd_arbiter.sv - two-requester round-robin read arbiter for the AXI4 DMA slave port
module axi_dma_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [7:0]            req0_len,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [7:0]            req1_len,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic                  rsp0_last,
  output logic                  rsp0_err,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic                  rsp1_last,
  output logic                  rsp1_err,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  busy
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, TOUT} state_t;

  state_t          state;
  logic            grant;
  logic            ptr;
  logic            drain;
  logic [7:0]      beat_cnt;
  logic [TW-1:0]   tcnt;

  logic                  win;
  logic                  sel_ready;
  logic                  in_data;
  logic                  in_tout;
  logic                  g_valid;
  logic                  g_last;
  logic                  g_err;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  r_hs;

  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;

  // ptr names the requester preferred on a tie; a lone requester always wins
  assign win       = (req0_valid & req1_valid) ? ptr : req1_valid;
  assign sel_ready = grant ? rsp1_ready : rsp0_ready;
  assign in_data   = (state == DATA);
  assign in_tout   = (state == TOUT);
  assign busy      = (state != IDLE);

  // R channel is a pure pass-through to the granted side; TOUT injects a synthetic error beat
  assign g_valid = in_data ? m_axi_rvalid : in_tout;
  assign g_data  = in_data ? m_axi_rdata : '0;
  assign g_last  = in_data ? m_axi_rlast : in_tout;
  assign g_err   = in_data ? (m_axi_rresp != 2'b00) : in_tout;

  assign rsp0_valid = g_valid & ~grant;
  assign rsp0_data  = grant ? '0 : g_data;
  assign rsp0_last  = g_last & ~grant;
  assign rsp0_err   = g_err & ~grant;
  assign rsp1_valid = g_valid & grant;
  assign rsp1_data  = grant ? g_data : '0;
  assign rsp1_last  = g_last & grant;
  assign rsp1_err   = g_err & grant;

  // after a timeout abort, late beats from the slave are swallowed while idle
  assign m_axi_rready = (in_data & sel_ready) | ((state == IDLE) & drain);
  assign r_hs         = in_data & m_axi_rvalid & sel_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      grant         <= 1'b0;
      ptr           <= 1'b0;
      drain         <= 1'b0;
      beat_cnt      <= '0;
      tcnt          <= '0;
      req0_ready    <= 1'b0;
      req1_ready    <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (drain && m_axi_rvalid && m_axi_rlast) drain <= 1'b0;
          if (req0_valid || req1_valid) begin
            grant         <= win;
            req0_ready    <= ~win;
            req1_ready    <= win;
            m_axi_araddr  <= win ? req1_addr : req0_addr;
            m_axi_arlen   <= win ? req1_len : req0_len;
            m_axi_arvalid <= 1'b1;
            drain         <= 1'b0;
            state         <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            ptr           <= ~grant;
            beat_cnt      <= '0;
            tcnt          <= '0;
            state         <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            tcnt <= '0;
            if (m_axi_rlast || beat_cnt == m_axi_arlen) state <= IDLE;
            else beat_cnt <= beat_cnt + 8'd1;
          end else if (TIMEOUT != 0 && tcnt == TLIM) begin
            state <= TOUT;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        TOUT: begin
          if (sel_ready) begin
            drain <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_dma_rd_arbiter.sv
// tb/tb_axi_dma_rd_arbiter.sv - directed scoreboard bench for axi_dma_rd_arbiter
module tb_axi_dma_rd_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_addr, req1_addr;
  logic [7:0]  req0_len, req1_len;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_valid, rsp0_ready, rsp0_last, rsp0_err;
  logic        rsp1_valid, rsp1_ready, rsp1_last, rsp1_err;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;
  beat_t sbq[$];

  always #5 clk = ~clk;

  axi_dma_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_len(req0_len),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_len(req1_len),
    .rsp0_data(rsp0_data), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_last(rsp0_last), .rsp0_err(rsp0_err),
    .rsp1_data(rsp1_data), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_last(rsp1_last), .rsp1_err(rsp1_err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic id, input logic [31:0] data, input logic last, input logic err);
    beat_t b;
    b.id = id; b.data = data; b.last = last; b.err = err;
    sbq.push_back(b);
  endtask

  task automatic pop_check(input logic id);
    beat_t b;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 1, 0);
      return;
    end
    b = sbq.pop_front();
    chk("rsp_id", id, b.id);
    chk("rsp_data", id ? rsp1_data : rsp0_data, b.data);
    chk("rsp_last", id ? rsp1_last : rsp0_last, b.last);
    chk("rsp_err", id ? rsp1_err : rsp0_err, b.err);
  endtask

  // waits for the AR request and checks grant, address, length and 1-cycle latency
  task automatic wait_grant(input logic id, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!m_axi_arvalid && n < 20);
    chk("ar_latency", n, 1);
    chk("ar_valid", m_axi_arvalid, 1);
    chk("ar_addr", m_axi_araddr, addr);
    chk("ar_len", m_axi_arlen, len);
    chk("grant0_ready", req0_ready, !id);
    chk("grant1_ready", req1_ready, id);
    chk("busy_addr", busy, 1);
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  // slave drives n beats; requester ready optionally toggles every cycle
  task automatic r_burst(input logic id, input int n, input logic [31:0] base,
                         input int err_beat, input bit toggle);
    int  cyc = 0;
    logic rdy;
    for (int i = 0; i < n; i++) begin
      bit done = 0;
      push_beat(id, base + i, (i == n - 1), (i == err_beat));
      while (!done) begin
        @(negedge clk);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = base + i;
        m_axi_rlast  = (i == n - 1);
        m_axi_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
        rdy = toggle ? cyc[0] : 1'b1;
        cyc++;
        if (id) rsp1_ready = rdy;
        else    rsp0_ready = rdy;
        #1;
        chk("rready_mirror", m_axi_rready, rdy);
        chk("other_valid", id ? rsp0_valid : rsp1_valid, 0);
        chk("rsp_valid", id ? rsp1_valid : rsp0_valid, 1);
        if (rdy) begin
          pop_check(id);
          done = 1;
        end
        if (cyc > 100) begin
          chk("beat_budget", cyc, 0);
          done = 1;
        end
      end
    end
    @(negedge clk);
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    chk("idle_after_burst", busy, 0);
  endtask

  initial begin
    resetn = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0; req0_len = 0; req1_len = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    m_axi_arready = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0; m_axi_rvalid = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_req_ready", {req0_ready, req1_ready}, 0);
    chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("arsize", m_axi_arsize, 3'd2);
    chk("arburst", m_axi_arburst, 2'b01);
    chk("arcache", m_axi_arcache, 4'b0011);
    chk("arprot", m_axi_arprot, 3'b000);
    resetn = 1'b1;

    // single request, arready already high
    @(negedge clk);
    req0_valid = 1; req0_addr = 32'h1000; req0_len = 8'd3; m_axi_arready = 1;
    #1;
    chk("ar_not_yet", m_axi_arvalid, 0);
    wait_grant(0, 32'h1000, 8'd3);
    @(negedge clk); #1;
    chk("ar_one_cycle", m_axi_arvalid, 0);
    chk("ready_pulse", req0_ready, 0);
    r_burst(0, 4, 32'hA000_0000, -1, 0);

    // AR stall with a competing request waiting
    m_axi_arready = 0;
    @(negedge clk);
    req0_valid = 1; req0_addr = 32'h2000; req0_len = 8'd5;
    wait_grant(0, 32'h2000, 8'd5);
    req1_valid = 1; req1_addr = 32'h2800; req1_len = 8'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("stall_arvalid", m_axi_arvalid, 1);
      chk("stall_araddr", m_axi_araddr, 32'h2000);
      chk("stall_arlen", m_axi_arlen, 8'd5);
      chk("stall_ready", {req0_ready, req1_ready}, 0);
    end
    req1_valid = 0; m_axi_arready = 1;
    r_burst(0, 6, 32'hB000_0000, -1, 0);

    // error response on beat 2 of 4
    @(negedge clk);
    req0_valid = 1; req0_addr = 32'h3000; req0_len = 8'd3;
    wait_grant(0, 32'h3000, 8'd3);
    r_burst(0, 4, 32'hC000_0000, 1, 0);

    // backpressure on requester 1, 8 beats
    @(negedge clk);
    req1_valid = 1; req1_addr = 32'h6000; req1_len = 8'd7;
    wait_grant(1, 32'h6000, 8'd7);
    r_burst(1, 8, 32'hD000_0000, -1, 1);

    // timeout: no R beats at all
    @(negedge clk);
    req0_valid = 1; req0_addr = 32'h7000; req0_len = 8'd3;
    wait_grant(0, 32'h7000, 8'd3);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      chk("tout_quiet", rsp0_valid, 0);
    end
    push_beat(0, 32'h0, 1, 1);
    @(negedge clk); #1;
    chk("tout_valid", rsp0_valid, 1);
    chk("tout_other", rsp1_valid, 0);
    pop_check(0);
    @(negedge clk); #1;
    chk("tout_idle", busy, 0);
    m_axi_rvalid = 1; m_axi_rlast = 1; m_axi_rdata = 32'hDEAD;
    #1;
    chk("drain_rready", m_axi_rready, 1);
    chk("drain_drop", {rsp0_valid, rsp1_valid}, 0);
    @(negedge clk);
    m_axi_rvalid = 0; m_axi_rlast = 0;

    // reset pulsed mid-DATA
    req1_valid = 1; req1_addr = 32'h8000; req1_len = 8'd3;
    wait_grant(1, 32'h8000, 8'd3);
    @(negedge clk);
    m_axi_rvalid = 1; m_axi_rdata = 32'h1234; rsp1_ready = 0;
    #1;
    chk("mid_valid", rsp1_valid, 1);
    resetn = 0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_mid_rready", m_axi_rready, 0);
    @(negedge clk);
    m_axi_rvalid = 0; rsp1_ready = 1; resetn = 1;

    // contention: both requesters continuously reissue
    @(negedge clk);
    req0_valid = 1; req0_addr = 32'h4000; req0_len = 8'd1;
    req1_valid = 1; req1_addr = 32'h5000; req1_len = 8'd1;
    begin
      logic exp_id = 1'b0;
      for (int b = 0; b < 4; b++) begin
        wait_grant(exp_id, exp_id ? 32'h5000 : 32'h4000, 8'd1);
        r_burst(exp_id, 2, 32'hE000_0000 + (b << 8), -1, 0);
        if (b < 3) begin
          if (exp_id) req1_valid = 1;
          else        req0_valid = 1;
        end
        exp_id = ~exp_id;
      end
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk); #1;
    chk("end_idle", busy, 0);
    chk("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
